// File: rtl/aes_pkg.sv
// Shared widths and the block-entry record for the AES output serializer.
package aes_pkg;

    localparam int AES_BLOCK_W       = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;

    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [AES_BLOCK_W-1:0] data;
    } blk_entry_t;

    localparam int AES_ENTRY_W = $bits(blk_entry_t);

    function automatic blk_entry_t mk_entry(input logic f, input logic l,
                                            input logic [AES_BLOCK_W-1:0] d);
        blk_entry_t e;
        e.first = f;
        e.last  = l;
        e.data  = d;
        return e;
    endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Block input from the AES core and 32-bit word stream toward the bus/DMA side.
interface aes_out_serializer_if;

    logic                             in_valid;
    logic                             in_first;
    logic                             in_last;
    logic [aes_pkg::AES_BLOCK_W-1:0]  in_pct;

    // Word stream: a word transfers on each edge where out_valid & out_ready.
    // Once out_valid rises it stays high and out_data stays stable until that transfer.
    logic                             out_valid;
    logic                             out_ready;
    logic [aes_pkg::AES_WORD_W-1:0]   out_data;
    logic                             out_sop;
    logic                             out_eop;
    logic                             out_bow;

    modport slave (
        input  in_valid, in_first, in_last, in_pct, out_ready,
        output out_valid, out_data, out_sop, out_eop, out_bow
    );

    modport master (
        output in_valid, in_first, in_last, in_pct, out_ready,
        input  out_valid, out_data, out_sop, out_eop, out_bow
    );

endinterface

// File: rtl/aes_blk_fifo.sv
// Synchronous show-ahead FIFO of AES result blocks with flush and occupancy level.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  blk_entry_t    wr,
    input  logic          pop,
    input  logic          flush,
    output blk_entry_t    head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    blk_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES result blocks and emits them as four 32-bit words each, MSW first.
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int AF_MARGIN = 1,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_out_serializer_if.slave  bus,
    input  logic                 in_flush,
    input  logic                 clr_overflow,
    output logic [LW-1:0]        level,
    output logic                 almost_full,
    output logic                 overflow
);

    localparam logic [LW-1:0] AF_TH    = LW'(DEPTH - AF_MARGIN);
    localparam logic [1:0]    LAST_IDX = 2'(AES_WORDS_PER_BLK - 1);

    blk_entry_t             head;
    blk_entry_t             wr_entry;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   hs;
    logic                   last_word;

    logic [AES_BLOCK_W-1:0] sh;
    logic [1:0]             idx;
    logic                   f;
    logic                   l;
    logic                   v;

    assign wr_entry  = mk_entry(bus.in_first, bus.in_last, bus.in_pct);
    assign hs        = v & bus.out_ready;
    assign last_word = (idx == LAST_IDX);

    // Reload straight from the FIFO head on the final-word handshake so bursts have no bubble.
    assign pop  = ~in_flush & ~empty & (~v | (hs & last_word));
    assign push = bus.in_valid & ~in_flush & (~full | pop);
    assign drop = bus.in_valid & ~in_flush & full & ~pop;

    aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wr    (wr_entry),
        .pop   (pop),
        .flush (in_flush),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            idx <= '0;
            f   <= 1'b0;
            l   <= 1'b0;
            v   <= 1'b0;
        end else if (in_flush) begin
            sh  <= '0;
            idx <= '0;
            f   <= 1'b0;
            l   <= 1'b0;
            v   <= 1'b0;
        end else if (pop) begin
            sh  <= head.data;
            f   <= head.first;
            l   <= head.last;
            idx <= '0;
            v   <= 1'b1;
        end else if (hs) begin
            if (last_word) begin
                sh  <= '0;
                idx <= '0;
                v   <= 1'b0;
            end else begin
                sh  <= {sh[AES_BLOCK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
                idx <= idx + 2'd1;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign almost_full   = (level >= AF_TH);
    assign bus.out_valid = v;
    assign bus.out_data  = sh[AES_BLOCK_W-1 -: AES_WORD_W];
    assign bus.out_sop   = v & (idx == 2'd0) & f;
    assign bus.out_eop   = v & last_word & l;
    assign bus.out_bow   = v & last_word;

endmodule
